// File: rtl/life_array_engine.sv
// 4-row Game of Life (B3/S23) engine driven by write_array/write_mem/run strobes.
// Define LIFE_TORUS_EN for toroidal wrap; otherwise out-of-grid neighbours are dead.
module life_array_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GEN_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_array,
    input  logic             run,
    input  logic [1:0]       pos,
    input  logic             write_mem,
    input  logic [WIDTH-1:0] row_in,
    output logic [WIDTH-1:0] row_out,
    output logic             row_valid,
    output logic             busy,
    output logic             done,
    output logic [GEN_W-1:0] generation
);

    typedef enum logic [2:0] {
        StIdle, StSnap, StCalc0, StCalc1, StCalc2, StCalc3, StFin
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] grid   [4];
    logic [WIDTH-1:0] shadow [4];
    logic [1:0]       calc_row, row_above, row_below;
    logic [WIDTH-1:0] row_up, row_mid, row_dn, row_next;

    function automatic logic [WIDTH-1:0] life_row(input logic [WIDTH-1:0] up,
                                                  input logic [WIDTH-1:0] mid,
                                                  input logic [WIDTH-1:0] dn);
        logic [WIDTH+1:0] eu, em, ed;
        logic [3:0]       n;
        life_row = '0;
        // Bit j of the extended rows holds column j-1.
`ifdef LIFE_TORUS_EN
        eu = {up[0], up, up[WIDTH-1]};
        em = {mid[0], mid, mid[WIDTH-1]};
        ed = {dn[0], dn, dn[WIDTH-1]};
`else
        eu = {1'b0, up, 1'b0};
        em = {1'b0, mid, 1'b0};
        ed = {1'b0, dn, 1'b0};
`endif
        for (int i = 0; i < int'(WIDTH); i++) begin
            n = 4'(eu[i]) + 4'(eu[i+1]) + 4'(eu[i+2]) + 4'(em[i]) + 4'(em[i+2])
              + 4'(ed[i]) + 4'(ed[i+1]) + 4'(ed[i+2]);
            life_row[i] = (n == 4'd3) || (mid[i] && (n == 4'd2));
        end
    endfunction

    always_comb begin
        calc_row = 2'd0;
        case (state_q)
            StCalc1: calc_row = 2'd1;
            StCalc2: calc_row = 2'd2;
            StCalc3: calc_row = 2'd3;
            default: calc_row = 2'd0;
        endcase
        row_above = calc_row - 2'd1;
        row_below = calc_row + 2'd1;
        row_mid   = shadow[calc_row];
`ifdef LIFE_TORUS_EN
        row_up    = shadow[row_above];
        row_dn    = shadow[row_below];
`else
        row_up    = (calc_row == 2'd0) ? '0 : shadow[row_above];
        row_dn    = (calc_row == 2'd3) ? '0 : shadow[row_below];
`endif
        row_next  = life_row(row_up, row_mid, row_dn);
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            StIdle:  if (run && !write_array && !write_mem) state_d = StSnap;
            StSnap:  begin busy = 1'b1; state_d = StCalc0; end
            StCalc0: begin busy = 1'b1; state_d = StCalc1; end
            StCalc1: begin busy = 1'b1; state_d = StCalc2; end
            StCalc2: begin busy = 1'b1; state_d = StCalc3; end
            StCalc3: begin busy = 1'b1; state_d = StFin;   end
            StFin:   begin done = 1'b1; state_d = StIdle;  end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            for (int r = 0; r < 4; r++) begin
                grid[r]   <= '0;
                shadow[r] <= '0;
            end
            row_out    <= '0;
            row_valid  <= 1'b0;
            generation <= '0;
        end else begin
            state_q   <= state_d;
            row_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (write_array) begin
                        grid[pos] <= row_in;
                    end else if (write_mem) begin
                        row_out   <= grid[pos];
                        row_valid <= 1'b1;
                    end
                end
                StSnap: begin
                    for (int r = 0; r < 4; r++) shadow[r] <= grid[r];
                end
                StCalc0, StCalc1, StCalc2, StCalc3: grid[calc_row] <= row_next;
                StFin:   generation <= generation + 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_life_array_engine.sv
// Randomised self-checking bench for life_array_engine against a cell-level Life model.
module tb_life_array_engine;

    localparam int W  = 8;
    localparam int GW = 16;

    logic          clk = 1'b0;
    logic          reset, write_array, run, write_mem;
    logic [1:0]    pos;
    logic [W-1:0]  row_in, row_out;
    logic          row_valid, busy, done;
    logic [GW-1:0] generation;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m [4];
    int           gen_m;

    life_array_engine #(.WIDTH(W), .GEN_W(GW)) dut (
        .clk         (clk),
        .reset       (reset),
        .write_array (write_array),
        .run         (run),
        .pos         (pos),
        .write_mem   (write_mem),
        .row_in      (row_in),
        .row_out     (row_out),
        .row_valid   (row_valid),
        .busy        (busy),
        .done        (done),
        .generation  (generation)
    );

    always #5 clk = ~clk;

    // Reference: count the 8 neighbours of every cell directly.
    function automatic void model_step();
        logic [W-1:0] nx [4];
        int n, rr, cc;
        logic alive;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < W; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        if (dr != 0 || dc != 0) begin
                            rr = r + dr;
                            cc = c + dc;
`ifdef LIFE_TORUS_EN
                            rr = (rr + 4) % 4;
                            cc = (cc + W) % W;
                            alive = m[rr][cc];
`else
                            alive = (rr >= 0 && rr < 4 && cc >= 0 && cc < W) ? m[rr][cc] : 1'b0;
`endif
                            if (alive) n++;
                        end
                    end
                end
                nx[r][c] = m[r][c] ? (n == 2 || n == 3) : (n == 3);
            end
        end
        for (int r = 0; r < 4; r++) m[r] = nx[r];
        gen_m = (gen_m + 1) % (1 << GW);
    endfunction

    task automatic load_row(input int p, input logic [W-1:0] v);
        @(negedge clk);
        write_array = 1'b1;
        pos         = 2'(p);
        row_in      = v;
        @(negedge clk);
        write_array = 1'b0;
        m[p]        = v;
    endtask

    task automatic read_row(input int p, output logic [W-1:0] v, output logic vld,
                            output logic vld_after);
        @(negedge clk);
        write_mem = 1'b1;
        pos       = 2'(p);
        @(negedge clk);
        write_mem = 1'b0;
        v         = row_out;
        vld       = row_valid;
        @(negedge clk);
        vld_after = row_valid;
    endtask

    task automatic run_gen(input bit lockout, output int busy_cnt, output int done_cnt,
                           output int done_idx, output int valid_cnt);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run       = 1'b0;
        busy_cnt  = 0;
        done_cnt  = 0;
        done_idx  = -1;
        valid_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_idx < 0) done_idx = k;
            end
            if (row_valid) valid_cnt++;
            if (lockout && k == 1) begin
                write_array = 1'b1; pos = 2'd2; row_in = 8'hFF; write_mem = 1'b1; run = 1'b1;
            end
            if (lockout && k == 2) begin
                write_array = 1'b0; write_mem = 1'b0; run = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        logic [W-1:0] v;
        logic vld, va;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (row_out !== '0) begin errors++; $display("FAIL reset_row_out got %h want 00", row_out); end
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_row_valid got %b want 0", row_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (generation !== '0) begin errors++; $display("FAIL reset_gen got %0d want 0", generation); end
        for (int r = 0; r < 4; r++) begin
            read_row(r, v, vld, va);
            checks++; if (v !== '0) begin errors++; $display("FAIL reset_row%0d got %h want 00", r, v); end
            checks++; if (vld !== 1'b1) begin errors++; $display("FAIL reset_valid%0d got %b want 1", r, vld); end
            checks++; if (va !== 1'b0) begin errors++; $display("FAIL reset_valid_drop%0d got %b want 0", r, va); end
        end
    endtask

    task automatic test_blinker();
        logic [W-1:0] v, want [4];
        logic vld, va;
        int bc, dc, di, vc;
        load_row(0, 8'h00); load_row(1, 8'h1C); load_row(2, 8'h00); load_row(3, 8'h00);
        for (int pass = 0; pass < 2; pass++) begin
            run_gen(1'b0, bc, dc, di, vc);
            model_step();
            if (pass == 0) begin want[0] = 8'h08; want[1] = 8'h08; want[2] = 8'h08; want[3] = 8'h00; end
            else           begin want[0] = 8'h00; want[1] = 8'h1C; want[2] = 8'h00; want[3] = 8'h00; end
            checks++; if (bc != 5) begin errors++; $display("FAIL blinker_busy_cycles got %0d want 5", bc); end
            checks++; if (dc != 1) begin errors++; $display("FAIL blinker_done_pulses got %0d want 1", dc); end
            checks++; if (di != 5) begin errors++; $display("FAIL blinker_done_cycle got %0d want 5", di); end
            checks++; if (generation !== GW'(pass + 1)) begin errors++; $display("FAIL blinker_gen got %0d want %0d", generation, pass + 1); end
            for (int r = 0; r < 4; r++) begin
                read_row(r, v, vld, va);
                checks++; if (v !== want[r]) begin errors++; $display("FAIL blinker_row%0d got %h want %h", r, v, want[r]); end
            end
        end
    endtask

    task automatic test_edge_blinker();
        logic [W-1:0] v;
        logic vld, va;
        int bc, dc, di, vc;
        load_row(0, 8'h83); load_row(1, 8'h00); load_row(2, 8'h00); load_row(3, 8'h00);
        run_gen(1'b0, bc, dc, di, vc);
        model_step();
        for (int r = 0; r < 4; r++) begin
            read_row(r, v, vld, va);
            checks++; if (v !== m[r]) begin errors++; $display("FAIL edge_row%0d got %h want %h", r, v, m[r]); end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] v;
        logic vld, va;
        int bc, dc, di, vc, gens;
        for (int it = 0; it < 6; it++) begin
            for (int r = 0; r < 4; r++) load_row(r, W'($urandom));
            gens = $urandom_range(1, 3);
            for (int g = 0; g < gens; g++) begin
                run_gen(1'b0, bc, dc, di, vc);
                model_step();
            end
            checks++; if (generation !== GW'(gen_m)) begin errors++; $display("FAIL random_gen got %0d want %0d", generation, gen_m); end
            for (int r = 0; r < 4; r++) begin
                read_row(r, v, vld, va);
                checks++; if (v !== m[r]) begin errors++; $display("FAIL random_row%0d got %h want %h", r, v, m[r]); end
            end
        end
    endtask

    task automatic test_busy_lockout();
        logic [W-1:0] v;
        logic vld, va;
        int bc, dc, di, vc;
        for (int r = 0; r < 4; r++) load_row(r, W'($urandom));
        run_gen(1'b1, bc, dc, di, vc);
        model_step();
        checks++; if (vc != 0) begin errors++; $display("FAIL lockout_row_valid got %0d want 0", vc); end
        checks++; if (dc != 1) begin errors++; $display("FAIL lockout_done_pulses got %0d want 1", dc); end
        checks++; if (bc != 5) begin errors++; $display("FAIL lockout_busy_cycles got %0d want 5", bc); end
        checks++; if (generation !== GW'(gen_m)) begin errors++; $display("FAIL lockout_gen got %0d want %0d", generation, gen_m); end
        for (int r = 0; r < 4; r++) begin
            read_row(r, v, vld, va);
            checks++; if (v !== m[r]) begin errors++; $display("FAIL lockout_row%0d got %h want %h", r, v, m[r]); end
        end
    endtask

    task automatic test_simultaneous();
        logic [W-1:0] v;
        logic vld, va;
        @(negedge clk);
        write_array = 1'b1; run = 1'b1; write_mem = 1'b1; pos = 2'd1; row_in = 8'h5A;
        @(negedge clk);
        write_array = 1'b0; run = 1'b0; write_mem = 1'b0;
        m[1] = 8'h5A;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy got %b want 0", busy); end
        checks++; if (row_valid !== 1'b0) begin errors++; $display("FAIL simul_row_valid got %b want 0", row_valid); end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL simul_busy_later got %b want 0", busy); end
        read_row(1, v, vld, va);
        checks++; if (v !== 8'h5A) begin errors++; $display("FAIL simul_row1 got %h want 5a", v); end
        checks++; if (generation !== GW'(gen_m)) begin errors++; $display("FAIL simul_gen got %0d want %0d", generation, gen_m); end
    endtask

    task automatic test_reset_mid();
        logic [W-1:0] v;
        logic vld, va;
        int dc;
        load_row(0, 8'h3C); load_row(1, 8'hA5); load_row(2, 8'h7E); load_row(3, 8'h18);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 4; r++) m[r] = '0;
        gen_m = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy got %b want 0", busy); end
        checks++; if (generation !== '0) begin errors++; $display("FAIL midreset_gen got %0d want 0", generation); end
        dc = 0;
        for (int k = 0; k < 8; k++) begin
            if (done) dc++;
            @(negedge clk);
        end
        checks++; if (dc != 0) begin errors++; $display("FAIL midreset_done got %0d want 0", dc); end
        for (int r = 0; r < 4; r++) begin
            read_row(r, v, vld, va);
            checks++; if (v !== '0) begin errors++; $display("FAIL midreset_row%0d got %h want 00", r, v); end
        end
    endtask

    initial begin
        reset       = 1'b1;
        write_array = 1'b0;
        run         = 1'b0;
        write_mem   = 1'b0;
        pos         = 2'd0;
        row_in      = '0;
        gen_m       = 0;
        for (int r = 0; r < 4; r++) m[r] = '0;
        test_reset();
        test_blinker();
        test_edge_blinker();
        test_random();
        test_busy_lockout();
        test_simultaneous();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_array_engine.md
Name: life_array_engine

Overview:
- Responder for the Controller strobe interface (write_array, run, pos, write_mem); executes each command issued by that sequencer.
- Holds a 4-row x WIDTH-column Game of Life grid. pos selects the row.
- write_array loads a row. run computes one generation, one row per cycle. write_mem emits a row toward memory.
- Sits between the Controller and the frame/display memory.

Parameters:
- WIDTH, 8, number of columns per row; row bit i is column i.
- GEN_W, 16, width of the generation counter.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- write_array  input  1  load strobe: grid[pos] <= row_in.
- run  input  1  start one generation update.
- pos  input  2  row index for write_array and write_mem.
- write_mem  input  1  read strobe: emit grid[pos] on row_out.
- row_in  input  WIDTH  row data for write_array.
- row_out  output  WIDTH  registered row data.
- row_valid  output  1  one-cycle pulse; row_out valid.
- busy  output  1  high while a generation is being computed.
- done  output  1  one-cycle pulse when a generation completes.
- generation  output  GEN_W  count of completed generations.

Behaviour:
- Reset (synchronous, active-high):
  - grid and shadow cleared to 0.
  - row_out=0, row_valid=0, busy=0, done=0, generation=0, state=IDLE.
  - Reset mid-computation aborts immediately; no done pulse.
- Strobes are sampled only in IDLE. Priority when more than one is high: write_array > write_mem > run. Lower-priority strobes in the same cycle are dropped.
- While busy=1, all three strobes are ignored (no queueing).
- write_array at edge T: grid[pos] updated at T. Visible to a write_mem sampled at T+1.
- write_mem at edge T: row_out=grid[pos] and row_valid=1 from T until T+1. row_valid is low otherwise; row_out holds its last value.
- State machine: IDLE -> SNAP -> CALC0 -> CALC1 -> CALC2 -> CALC3 -> FIN -> IDLE.
  - IDLE: run accepted -> SNAP.
  - SNAP, 1 cycle: shadow <= grid; busy=1.
  - CALCr, 1 cycle each: grid[r] <= next(shadow, r); busy=1. Next state is always computed from shadow, never from partially updated grid.
  - FIN, 1 cycle: busy=0, done=1, generation <= generation+1 (wraps modulo 2^GEN_W).
- Timing from run accepted at edge T:
  - busy high for cycles T+1..T+5.
  - done high in cycle T+6.
  - New strobes are accepted from the FIN cycle's edge onward (end of T+6).
- next rule (B3/S23), per cell, using the 8 neighbours in shadow:
  - Neighbour count n is 4 bits, range 0..8.
  - Live cell survives if n=2 or n=3.
  - Dead cell is born if n=3.
  - Otherwise the cell is 0.
- Column neighbours of column i are i-1 and i+1. Row neighbours of row r are r-1 and r+1.
- Edge handling is set by the optional feature below.

Optional Feature:
- Macro: LIFE_TORUS_EN.
- Defined: toroidal grid. Column -1 maps to WIDTH-1, column WIDTH maps to 0. Row -1 maps to 3, row 4 maps to 0.
- Undefined: out-of-range neighbours read as dead (0). No wrap in either axis.

Test Plan (WIDTH=8):
- Reset -> row_out=0x00, row_valid=0, busy=0, done=0, generation=0. Then write_mem at pos=0..3 returns 0x00 each, with row_valid pulsing 1 cycle after each strobe.
- Blinker, either build: load rows {0x00,0x1C,0x00,0x00}, then pulse run.
  - busy high exactly 5 cycles, then done pulses once; generation=1.
  - Readback rows = {0x08,0x08,0x08,0x00}.
  - Second run -> rows {0x00,0x1C,0x00,0x00}; generation=2.
- Edge blinker: load row0=0x83, other rows 0, then run.
  - With LIFE_TORUS_EN: rows = {0x01,0x01,0x00,0x01}.
  - Without LIFE_TORUS_EN: all rows 0x00.
- Busy lockout: pulse run, then during busy pulse write_array (pos=2, row_in=0xFF), write_mem, and run.
  - row2 not overwritten; no row_valid pulse.
  - Exactly one done pulse; generation increments by exactly 1.
- Simultaneous strobes: write_array+run+write_mem together in IDLE (pos=1, row_in=0x5A).
  - Only the load occurs: no busy, no row_valid.
  - Subsequent write_mem pos=1 returns 0x5A.
- Reset mid-computation: assert reset during CALC1.
  - Next cycle busy=0, no done pulse, generation=0.
  - All rows read back as 0x00.
